// File: rtl/tx_bf_ch_pulser.sv
// Transmit beamforming channel: per-beam delay LUT followed by a bipolar pulser burst.
// One instance per array element; all channels share tx_start so their delays steer the beam.
module tx_bf_ch_pulser #(
    parameter int ADDR_WD  = 7,
    parameter int DELAY_WD = 12,
    parameter int HPER_WD  = 8,
    parameter int NCYC_WD  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_WD-1:0]  tx_lut_addr,
    input  logic [DELAY_WD-1:0] tx_lut_din,
    input  logic                tx_lut_we,
    input  logic [ADDR_WD-1:0]  beam_idx,
    input  logic [HPER_WD-1:0]  half_period,
    input  logic [NCYC_WD-1:0]  num_cycles,
    input  logic                tx_start,
    input  logic                tx_abort,
    output logic                pulse_p,
    output logic                pulse_n,
    output logic                tx_busy,
    output logic                tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DELAY,
        S_PHI,
        S_PLO,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DELAY_WD-1:0] lut [2**ADDR_WD];
    logic [DELAY_WD-1:0] lut_rd_p1;

    logic [HPER_WD-1:0]  hper_q,   hper_nxt;
    logic [NCYC_WD-1:0]  ncyc_q,   ncyc_nxt;
    logic [DELAY_WD-1:0] dly_cnt,  dly_nxt;
    logic [HPER_WD-1:0]  hcnt,     hcnt_nxt;
    logic [NCYC_WD-1:0]  cyc_cnt,  cyc_nxt;
    logic [NCYC_WD:0]    cyc_inc;

    // The read address is beam_idx as sampled with tx_start, so LOAD sees
    // LUT[beam_idx] from the start cycle; a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (tx_lut_we) begin
            lut[tx_lut_addr] <= tx_lut_din;
        end
        lut_rd_p1 <= lut[beam_idx];
    end

    assign cyc_inc = {1'b0, cyc_cnt} + (NCYC_WD+1)'(1);

    always_comb begin
        state_nxt = state;
        hper_nxt  = hper_q;
        ncyc_nxt  = ncyc_q;
        dly_nxt   = dly_cnt;
        hcnt_nxt  = hcnt;
        cyc_nxt   = cyc_cnt;
        case (state)
            S_IDLE: begin
                if (tx_start && !tx_abort) begin
                    state_nxt = S_LOAD;
                    hper_nxt  = (half_period == '0) ? HPER_WD'(1) : half_period;
                    ncyc_nxt  = num_cycles;
                end
            end
            S_LOAD: begin
                dly_nxt  = lut_rd_p1;
                hcnt_nxt = hper_q;
                cyc_nxt  = '0;
                if (lut_rd_p1 != '0) begin
                    state_nxt = S_DELAY;
                end else if (ncyc_q == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_PHI;
                end
            end
            S_DELAY: begin
                if (dly_cnt <= DELAY_WD'(1)) begin
                    state_nxt = (ncyc_q == '0) ? S_DONE : S_PHI;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt - DELAY_WD'(1);
                end
            end
            S_PHI: begin
                if (hcnt <= HPER_WD'(1)) begin
                    state_nxt = S_PLO;
                    hcnt_nxt  = hper_q;
                end else begin
                    hcnt_nxt = hcnt - HPER_WD'(1);
                end
            end
            S_PLO: begin
                if (hcnt <= HPER_WD'(1)) begin
                    hcnt_nxt  = hper_q;
                    cyc_nxt   = cyc_inc[NCYC_WD-1:0];
                    state_nxt = (cyc_inc < {1'b0, ncyc_q}) ? S_PHI : S_DONE;
                end else begin
                    hcnt_nxt = hcnt - HPER_WD'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Abort wins over everything, including a fresh tx_start.
        if (tx_abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end
    end

    // Outputs decode the next state so they are registered yet aligned with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            hper_q  <= '0;
            ncyc_q  <= '0;
            dly_cnt <= '0;
            hcnt    <= '0;
            cyc_cnt <= '0;
            pulse_p <= 1'b0;
            pulse_n <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            hper_q  <= hper_nxt;
            ncyc_q  <= ncyc_nxt;
            dly_cnt <= dly_nxt;
            hcnt    <= hcnt_nxt;
            cyc_cnt <= cyc_nxt;
            pulse_p <= (state_nxt == S_PHI);
            pulse_n <= (state_nxt == S_PLO);
            tx_busy <= (state_nxt != S_IDLE);
            tx_done <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_tx_bf_ch_pulser.sv
// Bench for tx_bf_ch_pulser: directed and randomized firings compared cycle by cycle
// against a timeline model computed from delay, half period and burst length.
`timescale 1ns/1ps
module tb_tx_bf_ch_pulser;
    localparam int AW = 7;
    localparam int DW = 12;
    localparam int HW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] tx_lut_addr;
    logic [DW-1:0] tx_lut_din;
    logic          tx_lut_we;
    logic [AW-1:0] beam_idx;
    logic [HW-1:0] half_period;
    logic [NW-1:0] num_cycles;
    logic          tx_start;
    logic          tx_abort;
    logic          pulse_p;
    logic          pulse_n;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int errors = 0;
    int lut_m [2**AW];

    tx_bf_ch_pulser #(.ADDR_WD(AW), .DELAY_WD(DW), .HPER_WD(HW), .NCYC_WD(NW)) dut (
        .clk(clk), .rst(rst),
        .tx_lut_addr(tx_lut_addr), .tx_lut_din(tx_lut_din), .tx_lut_we(tx_lut_we),
        .beam_idx(beam_idx), .half_period(half_period), .num_cycles(num_cycles),
        .tx_start(tx_start), .tx_abort(tx_abort),
        .pulse_p(pulse_p), .pulse_n(pulse_n), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #12 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input int addr, input int data);
        tx_lut_we   = 1'b1;
        tx_lut_addr = AW'(addr);
        tx_lut_din  = DW'(data);
        lut_m[addr] = data;
        step();
        tx_lut_we = 1'b0;
    endtask

    // One firing from the current cycle (cycle 0). Negative event cycles mean "none".
    task automatic fire(input string tag, input int beam, input int h, input int n,
                        input int abort_at, input int start2_at, input int rst_at,
                        input int wr_at, input int wr_addr, input int wr_data);
        int d, he, t_p, t_done, cut, ph;
        logic ep, en, eb, ed;
        he     = (h == 0) ? 1 : h;
        d      = lut_m[beam];
        t_p    = 2 + d;
        t_done = t_p + 2 * he * n;
        cut    = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : 1 << 30);
        for (int c = 0; c <= t_done + 2; c++) begin
            if (c == 0) begin
                beam_idx    = AW'(beam);
                half_period = HW'(h);
                num_cycles  = NW'(n);
            end else begin
                beam_idx    = AW'($urandom_range(0, 2**AW - 1));
                half_period = HW'($urandom_range(0, 7));
                num_cycles  = NW'($urandom_range(0, 15));
            end
            tx_start  = (c == 0) || (c == start2_at);
            tx_abort  = (c == abort_at);
            rst       = (c == rst_at);
            tx_lut_we = (c == wr_at);
            if (c == wr_at) begin
                tx_lut_addr     = AW'(wr_addr);
                tx_lut_din      = DW'(wr_data);
                lut_m[wr_addr]  = wr_data;
            end
            ep = 1'b0; en = 1'b0; eb = 1'b0; ed = 1'b0;
            if (c <= cut) begin
                eb = (c >= 1) && (c <= t_done);
                ed = (c == t_done);
                if (c >= t_p && c < t_done) begin
                    ph = (c - t_p) / he;
                    ep = (ph % 2) == 0;
                    en = (ph % 2) == 1;
                end
            end
            chk($sformatf("%s c%0d pulse_p", tag, c), pulse_p, ep);
            chk($sformatf("%s c%0d pulse_n", tag, c), pulse_n, en);
            chk($sformatf("%s c%0d tx_busy", tag, c), tx_busy, eb);
            chk($sformatf("%s c%0d tx_done", tag, c), tx_done, ed);
            chk($sformatf("%s c%0d p_n_excl", tag, c), pulse_p & pulse_n, 1'b0);
            step();
        end
        tx_start  = 1'b0;
        tx_abort  = 1'b0;
        rst       = 1'b0;
        tx_lut_we = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        tx_lut_addr = '0;
        tx_lut_din  = '0;
        tx_lut_we   = 1'b0;
        beam_idx    = '0;
        half_period = '0;
        num_cycles  = '0;
        tx_start    = 1'b0;
        tx_abort    = 1'b0;
        step();
        step();
        chk("reset pulse_p", pulse_p, 1'b0);
        chk("reset pulse_n", pulse_n, 1'b0);
        chk("reset tx_busy", tx_busy, 1'b0);
        chk("reset tx_done", tx_done, 1'b0);
        rst = 1'b0;
        step();

        for (int a = 0; a < 2**AW; a++) begin
            lut_write(a, int'($urandom_range(0, 15)));
        end
        lut_write(3, 5);
        lut_write(0, 0);
        lut_write(1, 4);
        lut_write(9, 300);

        fire("t1_basic",   3, 2, 2, -1, -1, -1, -1, 0, 0);
        fire("t2_h0",      0, 0, 1, -1, -1, -1, -1, 0, 0);
        fire("t3_n0",      1, 2, 0, -1, -1, -1, -1, 0, 0);
        fire("t4_restart", 3, 2, 2, -1,  8, -1, -1, 0, 0);
        fire("t5_abort",   3, 2, 2,  9, -1, -1, -1, 0, 0);
        fire("t5_after",   3, 2, 2, -1, -1, -1, -1, 0, 0);
        fire("t6_wr_same", 3, 2, 2, -1, -1, -1,  0, 3, 9);
        fire("t6_new_d",   3, 2, 2, -1, -1, -1,  4, 2, 6);
        fire("t6_rst",     3, 2, 2, -1, -1, 14, -1, 0, 0);
        fire("t6_retain",  3, 1, 1, -1, -1, -1, -1, 0, 0);
        fire("long_d",     9, 1, 1, -1, -1, -1, -1, 0, 0);
        fire("max_n",      0, 1, 15, -1, -1, -1, -1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            fire($sformatf("rnd%0d", i),
                 int'($urandom_range(0, 2**AW - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), -1, -1, -1,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2**AW - 1)),
                 int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
